// File: rtl/lc3b_pmem_responder.sv
// lc3b_pmem_responder: line-granular physical-memory responder for the LC-3b
// cache-to-memory interface. A request is latched on acceptance and answered
// with a one-cycle pmem_resp after LATENCY busy cycles. Lines live in an
// uninitialised array indexed by the low LINE_ADDR_BITS of the line address.
// Optional build macro LC3B_PMEM_PROTOCOL_CHECK_EN adds the sticky
// pmem_proto_err output. This output flags a requester that changes or drops
// its request while the responder is busy.
module lc3b_pmem_responder #(
    parameter int LATENCY        = 4,
    parameter int LINE_ADDR_BITS = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic [127:0] pmem_rdata,
    output logic         pmem_resp,
    output logic         pmem_busy
`ifdef LC3B_PMEM_PROTOCOL_CHECK_EN
    ,
    output logic         pmem_proto_err
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int DEPTH = 2 ** LINE_ADDR_BITS;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [3:0]                  r_cnt;
    logic [3:0]                  w_cnt_next;
    logic                        w_accept;
    logic                        w_done;
    logic                        r_op_write;
    logic [LINE_ADDR_BITS-1:0]   r_addr;
    logic [127:0]                r_wdata;
    logic [127:0]                r_rdata;
    logic [127:0]                r_mem [DEPTH];

    // Byte-offset bits (and, with a small array, the upper line bits) carry no
    // meaning here. Folding them keeps the whole address visibly consumed.
    logic                        w_unused_addr;
    assign w_unused_addr = ^pmem_address;

    // Next-state, countdown and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        pmem_resp    = 1'b0;
        pmem_busy    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (pmem_read || pmem_write) begin
                    w_accept     = 1'b1;
                    w_cnt_next   = 4'(LATENCY - 1);
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                pmem_busy = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_done       = 1'b1;
                    w_state_next = ST_RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                pmem_busy    = 1'b1;
                pmem_resp    = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register and latency counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Capture the request on acceptance. When both lines are high, write wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else if (w_accept) begin
            r_op_write <= pmem_write;
            r_addr     <= pmem_address[LINE_ADDR_BITS+3:4];
            r_wdata    <= pmem_wdata;
        end
    end

    // Line storage has no reset, so it can map onto block RAM. A reset
    // forces the state to IDLE, which keeps w_done low and blocks the write.
    always_ff @(posedge clk) begin
        if (w_done && r_op_write) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    // Registered read data. It holds until the next completed read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_done && !r_op_write) begin
            r_rdata <= r_mem[r_addr];
        end
    end

    assign pmem_rdata = r_rdata;

`ifdef LC3B_PMEM_PROTOCOL_CHECK_EN
    logic [11:0] r_line_full;
    logic        r_proto_err;
    logic        w_violation;

    // A busy-phase violation is a dropped request, a moved line, or a changed op.
    assign w_violation = (r_state == ST_BUSY) &&
                         (!(pmem_read || pmem_write) ||
                          (pmem_address[15:4] != r_line_full) ||
                          (pmem_write != r_op_write));

    // Keep the full line address for checking, and latch the error as sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_full <= 12'd0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_line_full <= pmem_address[15:4];
            end
            if (w_violation) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign pmem_proto_err = r_proto_err;
`endif

endmodule

// File: tb/tb_lc3b_pmem_responder.sv
// Directed scoreboard bench for lc3b_pmem_responder (LATENCY=4, LINE_ADDR_BITS=5).
module tb_lc3b_pmem_responder;

    logic         clk;
    logic         rst_n;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic         pmem_busy;
`ifdef LC3B_PMEM_PROTOCOL_CHECK_EN
    logic         pmem_proto_err;
`endif

    lc3b_pmem_responder #(.LATENCY(4), .LINE_ADDR_BITS(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .pmem_busy    (pmem_busy)
`ifdef LC3B_PMEM_PROTOCOL_CHECK_EN
        ,
        .pmem_proto_err (pmem_proto_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [127:0] exp_q [$];
    logic [127:0] model_mem [32];
    logic [127:0] last_rd;

    localparam logic [127:0] D1  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] D2  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] A5  = {16{8'hA5}};
    localparam logic [127:0] ONE = {128{1'b1}};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [127:0] d);
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = a;
        pmem_wdata   = d;
    endtask

    // Scoreboard push: write updates the model and expects rdata unchanged.
    task automatic push_exp(input logic wr, input logic [15:0] a, input logic [127:0] d);
        int line;
        line = int'((a >> 4) & 16'h1F);
        if (wr) begin
            model_mem[line] = d;
        end else begin
            last_rd = model_mem[line];
        end
        exp_q.push_back(last_rd);
    endtask

    // Count cycles until pmem_resp is seen, bounded.
    task automatic wait_resp(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!pmem_resp && n < 20);
    endtask

    task automatic pop_check(input string tag);
        logic [127:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 128'd1, 128'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_rdata"}, pmem_rdata, e);
        end
    endtask

    // Full transaction: issue, time the response, check data, release.
    task automatic txn(input string tag, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [127:0] d);
        int n;
        push_exp(wr, a, d);
        drive(rd, wr, a, d);
        wait_resp(n);
        chk({tag, "_latency"}, 128'(n), 128'd5);
        chk({tag, "_busy"}, 128'(pmem_busy), 128'd1);
        pop_check(tag);
        @(posedge clk);
        #1;
        chk({tag, "_resp_width"}, 128'(pmem_resp), 128'd0);
        drive(1'b0, 1'b0, 16'h0, 128'h0);
        $display("txn %s rd=%0b wr=%0b addr=%h latency=%0d rdata=%h", tag, rd, wr, a, n, pmem_rdata);
    endtask

    initial begin
        int n;
        last_rd = '0;
        drive(1'b0, 1'b0, 16'h0, 128'h0);
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle after reset: no response, not busy, read data cleared.
        for (int i = 0; i < 10; i++) begin
            chk("reset_resp", 128'(pmem_resp), 128'd0);
            chk("reset_busy", 128'(pmem_busy), 128'd0);
            chk("reset_rdata", pmem_rdata, 128'd0);
            @(posedge clk);
            #1;
        end
        $display("txn reset_idle cycles=10");

        // Write then read with a different byte offset in the same line.
        txn("wr_0010", 1'b0, 1'b1, 16'h0010, D1);
        txn("rd_001F", 1'b1, 1'b0, 16'h001F, 128'h0);

        // Read and write both high: the write wins, and rdata stays at D1.
        txn("rw_0020", 1'b1, 1'b1, 16'h0020, A5);
        txn("rd_0020", 1'b1, 1'b0, 16'h0020, 128'h0);

        // Aliasing: line 0x20 wraps to line 0 with 5 line-address bits.
        txn("wr_0200", 1'b0, 1'b1, 16'h0200, D2);

        // Back-to-back: the read stays high through the idle cycle after RESP.
        push_exp(1'b0, 16'h0000, 128'h0);
        push_exp(1'b0, 16'h0000, 128'h0);
        drive(1'b1, 1'b0, 16'h0000, 128'h0);
        wait_resp(n);
        chk("b2b_first_latency", 128'(n), 128'd5);
        pop_check("b2b_first");
        wait_resp(n);
        chk("b2b_second_gap", 128'(n), 128'd6);
        pop_check("b2b_second");
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 16'h0, 128'h0);
        $display("txn b2b_rd_0000 gap=%0d rdata=%h", n, pmem_rdata);

        // Reset during the second BUSY cycle aborts the write.
        txn("wr0_0030", 1'b0, 1'b1, 16'h0030, 128'h0);
        drive(1'b0, 1'b1, 16'h0030, ONE);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 128'(pmem_busy), 128'd0);
        chk("abort_resp", 128'(pmem_resp), 128'd0);
        chk("abort_rdata", pmem_rdata, 128'd0);
        last_rd = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 128'h0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_resp", 128'(pmem_resp), 128'd0);
            chk("abort_idle", 128'(pmem_busy), 128'd0);
        end
        $display("txn abort_wr_0030 rst_mid_busy");
        txn("rd_0030", 1'b1, 1'b0, 16'h0030, 128'h0);

        chk("queue_empty", 128'(exp_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc3b_pmem_responder.md
Name: lc3b_pmem_responder

Overview:
- Line-granular physical-memory responder: the memory end of the cache-to-physical-memory interface.
- Accepts 128-bit line read/write requests from the L1 cache controller and returns pmem_resp after a programmable latency.
- Stores lines in an internal array indexed by line address (addr[15:4]).
- Used as the synthesizable backing store in cache bring-up and as the memory model in cache verification.

Parameters:
- LATENCY, 4: BUSY cycles between request acceptance and the response cycle; legal range 1..15.
- LINE_ADDR_BITS, 5: number of line-address bits used; array holds 2**LINE_ADDR_BITS 128-bit lines; legal range 1..12.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- pmem_read  input  1  line read request; held high by requester until pmem_resp
- pmem_write  input  1  line write request; held high by requester until pmem_resp
- pmem_address  input  16  byte address; bits [3:0] ignored, line address = [15:4]
- pmem_wdata  input  128  write line data, 16 bytes, byte 0 in bits [7:0]
- pmem_rdata  output  128  read line data; valid in the pmem_resp cycle of a read
- pmem_resp  output  1  one-cycle completion pulse
- pmem_busy  output  1  high in BUSY and RESP states

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pmem_resp=0, pmem_busy=0, pmem_rdata=0, counter=0.
  - Array contents are not reset.
  - Reset asserted mid-transaction aborts it: no write is performed and no response is issued.
- States:
  - IDLE: on a clk edge with pmem_read|pmem_write high:
    - latch op, line address (pmem_address[LINE_ADDR_BITS+3:4]) and pmem_wdata;
    - counter=LATENCY-1;
    - go to BUSY.
  - BUSY: counter decrements each cycle. On the edge where counter==0:
    - write: array[latched addr] <= latched wdata;
    - read: pmem_rdata <= array[latched addr];
    - go to RESP.
  - RESP: pmem_resp=1 for exactly one cycle, then IDLE.
- Latency: request first seen high in cycle 0 produces pmem_resp in cycle LATENCY+1. For LATENCY=4 that is cycle 5.
- Handshake:
  - Requester samples pmem_resp at the edge ending RESP and deasserts request in the following cycle, so the IDLE cycle after RESP sees no request.
  - A request still high in that IDLE cycle is accepted as a new transaction (back-to-back allowed, minimum 2 idle-free cycles between responses is not required).
- Inputs are latched at acceptance. Changes to pmem_address/pmem_wdata/op during BUSY have no effect.
- Simultaneous pmem_read and pmem_write at acceptance: write wins and the transaction is treated as a write; pmem_rdata is unchanged.
- Address wrap: upper address bits beyond LINE_ADDR_BITS+3 are ignored; addresses alias modulo the array size.
- pmem_rdata holds its value until the next completed read. Writes never change pmem_rdata.
- Read of a never-written line returns the array's uninitialised value; no X-masking is applied.

Optional Feature:
- Macro: LC3B_PMEM_PROTOCOL_CHECK_EN
- With the macro: extra output port pmem_proto_err (1 bit, reset 0, sticky until rst_n). Set on the clk edge where, during BUSY:
  - the request drops to 0 on both lines; or
  - pmem_address[15:4] differs from the latched line address; or
  - the op differs from the latched op.
  The transaction completes normally regardless.
- Without the macro: port and checking logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset then idle 10 cycles -> pmem_resp=0, pmem_busy=0, pmem_rdata=0 throughout.
- Write addr 0x0010 data 0x00112233_44556677_8899AABB_CCDDEEFF, hold until resp -> pmem_resp exactly in cycle 5 (LATENCY=4), one cycle wide. Then read 0x001F -> same 128-bit value returned in its resp cycle.
- Read and write both high, addr 0x0020, wdata all 0xA5 -> treated as write, pmem_rdata unchanged. A later read of 0x0020 returns all 0xA5.
- Write 0x0200 then read 0x0000 (LINE_ADDR_BITS=5) -> aliasing returns the 0x0200 data. Back-to-back read held through the IDLE cycle after RESP -> second resp 6 cycles after the first.
- Assert rst_n=0 in the second BUSY cycle of a write to 0x0030 (previous contents 0x0) -> pmem_resp never pulses, state IDLE. A subsequent read returns 0x0.
- With LC3B_PMEM_PROTOCOL_CHECK_EN: change address 0x0040->0x0050 mid-BUSY -> pmem_proto_err=1 at the next edge and stays 1. The resp still arrives and reflects line 0x0040.
